// File: rtl/bitty_pkg.sv
// Shared widths and fetch-state encoding for the bitty core.
package bitty_pkg;

   localparam int ADDR_W  = 8;
   localparam int INSTR_W = 16;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_REQ    = 3'd1,
      S_WAIT   = 3'd2,
      S_HOLD   = 3'd3,
      S_HALTED = 3'd4
   } fetch_state_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: load wins over increment, otherwise hold.
module fetch_pc_reg #(
   parameter int ADDR_W   = bitty_pkg::ADDR_W,
   parameter int RESET_PC = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              inc,
   input  logic [ADDR_W-1:0] load_val,
   output logic [ADDR_W-1:0] pc
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc <= ADDR_W'(RESET_PC);
      end else if (load) begin
         pc <= load_val;
      end else if (inc) begin
         // Wraps modulo 2^ADDR_W by construction.
         pc <= pc + ADDR_W'(1);
      end
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: one imem read per instruction, held for decode
// on valid/ready, with branch redirect (squashing in-flight reads) and halt.
module fetch_ctrl
   import bitty_pkg::*;
#(
   parameter int ADDR_W   = bitty_pkg::ADDR_W,
   parameter int INSTR_W  = bitty_pkg::INSTR_W,
   parameter int RESET_PC = 0
) (
   input  logic               clk,
   input  logic               reset,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_rvalid,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               instr_valid,
   output logic [INSTR_W-1:0] instr_out,
   output logic [ADDR_W-1:0]  instr_pc,
   input  logic               instr_ready,
   input  logic               br_valid,
   input  logic [ADDR_W-1:0]  br_target,
   input  logic               halt,
   output logic               busy
);

   // Handshake: an instruction transfers on a cycle where instr_valid and
   // instr_ready are both high; instr_out/instr_pc are stable until then.

   fetch_state_t      state;
   logic              squash;
   logic [ADDR_W-1:0] pc;
   logic              pc_inc;
   logic              take_data;

   assign take_data = (state == S_WAIT) && imem_rvalid && !squash && !br_valid;
   assign pc_inc    = take_data;

   fetch_pc_reg #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk      (clk),
      .reset    (reset),
      .load     (br_valid),
      .inc      (pc_inc),
      .load_val (br_target),
      .pc       (pc)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         squash    <= 1'b0;
         instr_out <= '0;
         instr_pc  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               state <= halt ? S_HALTED : S_REQ;
            end
            S_REQ: begin
               if (br_valid) squash <= 1'b1;
               state <= S_WAIT;
            end
            S_WAIT: begin
               if (imem_rvalid) begin
                  if (squash || br_valid) begin
                     // Stale response: drop it and refetch from the new pc.
                     squash <= 1'b0;
                     state  <= S_REQ;
                  end else begin
                     instr_out <= imem_rdata;
                     instr_pc  <= pc;
                     state     <= S_HOLD;
                  end
               end else if (br_valid) begin
                  squash <= 1'b1;
               end
            end
            S_HOLD: begin
               // A branch kills the held instruction whether or not it was accepted.
               if (br_valid || instr_ready) state <= halt ? S_HALTED : S_REQ;
            end
            S_HALTED: begin
               if (!halt) state <= S_REQ;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign imem_req    = (state == S_REQ);
   assign instr_valid = (state == S_HOLD);
   assign busy        = (state == S_REQ) || (state == S_WAIT) || (state == S_HOLD);
   assign imem_addr   = pc;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: in-order fetch, stall, branch squash, wrap, halt, reset.
module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [7:0]  imem_addr;
   logic        imem_rvalid;
   logic [15:0] imem_rdata;
   logic        instr_valid;
   logic [15:0] instr_out;
   logic [7:0]  instr_pc;
   logic        instr_ready;
   logic        br_valid;
   logic [7:0]  br_target;
   logic        halt;
   logic        busy;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Memory model: auto mode answers each req one cycle later with A000+addr.
   logic        mem_auto = 1'b1;
   logic        mem_rvalid = 1'b0;
   logic [15:0] mem_rdata = '0;
   logic        req_d = 1'b0;
   logic [7:0]  addr_d = '0;
   logic        man_rvalid = 1'b0;
   logic [15:0] man_rdata = '0;

   assign imem_rvalid = mem_auto ? mem_rvalid : man_rvalid;
   assign imem_rdata  = mem_auto ? mem_rdata  : man_rdata;

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (mem_auto) begin
         mem_rvalid = req_d;
         mem_rdata  = 16'hA000 + {8'h00, addr_d};
         req_d      = imem_req;
         addr_d     = imem_addr;
      end else begin
         mem_rvalid = 1'b0;
         req_d      = 1'b0;
      end
   end

   fetch_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .instr_valid (instr_valid),
      .instr_out   (instr_out),
      .instr_pc    (instr_pc),
      .instr_ready (instr_ready),
      .br_valid    (br_valid),
      .br_target   (br_target),
      .halt        (halt),
      .busy        (busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, ".req"},   {31'd0, imem_req},    32'd0);
      check({tag, ".addr"},  {24'd0, imem_addr},   32'd0);
      check({tag, ".valid"}, {31'd0, instr_valid}, 32'd0);
      check({tag, ".out"},   {16'd0, instr_out},   32'd0);
      check({tag, ".pc"},    {24'd0, instr_pc},    32'd0);
      check({tag, ".busy"},  {31'd0, busy},        32'd0);
   endtask

   initial begin
      reset       = 1'b1;
      instr_ready = 1'b1;
      br_valid    = 1'b0;
      br_target   = '0;
      halt        = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("rst");

      // 1: steady fetch, one instruction per 3 cycles.
      @(negedge clk);
      reset = 1'b0;
      cyc   = 0;
      for (int k = 1; k <= 7; k++) begin
         tick();
         check($sformatf("t1.req%0d", k), {31'd0, imem_req}, {31'd0, (k == 1 || k == 4 || k == 7)});
         check($sformatf("t1.val%0d", k), {31'd0, instr_valid}, {31'd0, (k == 3 || k == 6)});
         if (k == 3 || k == 6) begin
            check($sformatf("t1.out%0d", k), {16'd0, instr_out}, (k == 3) ? 32'hA000 : 32'hA001);
            check($sformatf("t1.pc%0d", k),  {24'd0, instr_pc},  (k == 3) ? 32'h0 : 32'h1);
         end
      end

      // 2: decode stalls for 5 cycles in HOLD.
      instr_ready = 1'b0;
      tick();
      tick();
      for (int k = 0; k < 5; k++) begin
         check("t2.valid", {31'd0, instr_valid}, 32'd1);
         check("t2.out",   {16'd0, instr_out},   32'hA002);
         check("t2.ipc",   {24'd0, instr_pc},    32'h2);
         check("t2.req",   {31'd0, imem_req},    32'd0);
         check("t2.addr",  {24'd0, imem_addr},   32'h3);
         tick();
      end
      instr_ready = 1'b1;
      tick();
      check("t2.resume", {31'd0, imem_req}, 32'd1);

      // 3: branch in WAIT; the stale 0xDEAD response must be dropped.
      mem_auto = 1'b0;
      tick();
      br_valid  = 1'b1;
      br_target = 8'h40;
      tick();
      br_valid = 1'b0;
      check("t3.addr",  {24'd0, imem_addr},   32'h40);
      check("t3.valid", {31'd0, instr_valid}, 32'd0);
      man_rvalid = 1'b1;
      man_rdata  = 16'hDEAD;
      tick();
      man_rvalid = 1'b0;
      check("t3.dropv", {31'd0, instr_valid}, 32'd0);
      check("t3.req",   {31'd0, imem_req},    32'd1);
      check("t3.reqa",  {24'd0, imem_addr},   32'h40);
      mem_auto = 1'b1;
      tick();
      instr_ready = 1'b0;
      tick();
      check("t3.valid2", {31'd0, instr_valid}, 32'd1);
      check("t3.ipc",    {24'd0, instr_pc},    32'h40);
      check("t3.out",    {16'd0, instr_out},   32'hA040);

      // 4: branch in HOLD while decode is stalled.
      br_valid  = 1'b1;
      br_target = 8'h10;
      tick();
      br_valid    = 1'b0;
      instr_ready = 1'b1;
      check("t4.kill", {31'd0, instr_valid}, 32'd0);
      check("t4.req",  {31'd0, imem_req},    32'd1);
      check("t4.addr", {24'd0, imem_addr},   32'h10);
      tick();
      tick();
      check("t4.ipc", {24'd0, instr_pc},  32'h10);
      check("t4.out", {16'd0, instr_out}, 32'hA010);

      // 5: fetch from 0xFF and wrap to 0x00.
      br_valid  = 1'b1;
      br_target = 8'hFF;
      tick();
      br_valid = 1'b0;
      check("t5.addr", {24'd0, imem_addr}, 32'hFF);
      tick();
      tick();
      check("t5.ipc",  {24'd0, instr_pc},  32'hFF);
      check("t5.out",  {16'd0, instr_out}, 32'hA0FF);
      check("t5.wrap", {24'd0, imem_addr}, 32'h00);
      tick();
      check("t5.req",   {31'd0, imem_req},  32'd1);
      check("t5.addr0", {24'd0, imem_addr}, 32'h00);

      // 6a: halt taken at the HOLD handshake, then released.
      halt = 1'b1;
      tick();
      tick();
      check("t6.hold", {31'd0, instr_valid}, 32'd1);
      tick();
      for (int k = 0; k < 3; k++) begin
         check("t6.hbusy", {31'd0, busy},        32'd0);
         check("t6.hreq",  {31'd0, imem_req},    32'd0);
         check("t6.hval",  {31'd0, instr_valid}, 32'd0);
         tick();
      end
      halt = 1'b0;
      tick();
      check("t6.rreq",  {31'd0, imem_req},  32'd1);
      check("t6.raddr", {24'd0, imem_addr}, 32'h01);
      check("t6.rbusy", {31'd0, busy},      32'd1);

      // 6b: reset mid-WAIT, then a stale rvalid lands in IDLE/REQ.
      mem_auto = 1'b0;
      tick();
      reset = 1'b1;
      #1;
      check_reset_outputs("t6.rst");
      @(negedge clk);
      reset      = 1'b0;
      man_rvalid = 1'b1;
      man_rdata  = 16'hDEAD;
      tick();
      check("t6.sreq", {31'd0, imem_req},    32'd1);
      check("t6.sval", {31'd0, instr_valid}, 32'd0);
      tick();
      man_rvalid = 1'b0;
      check("t6.wval",  {31'd0, instr_valid}, 32'd0);
      check("t6.wbusy", {31'd0, busy},        32'd1);
      tick();
      check("t6.wval2", {31'd0, instr_valid}, 32'd0);
      man_rvalid = 1'b1;
      man_rdata  = 16'h1234;
      tick();
      man_rvalid = 1'b0;
      check("t6.fval", {31'd0, instr_valid}, 32'd1);
      check("t6.fout", {16'd0, instr_out},   32'h1234);
      check("t6.fpc",  {24'd0, instr_pc},    32'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction-fetch sequencer for the bitty core. It owns the program counter, issues one read per instruction to instruction memory, and holds each returned instruction for the decoder on a valid/ready handshake. It also applies branch redirects from execute and handles halt. It sits between imem and the decode stage and replaces ad-hoc PC enable wiring with a single controlled sequence.

Parameters:
ADDR_W, 8, PC / imem address width
INSTR_W, 16, instruction width
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
imem_req  out  1  single-cycle read strobe to imem
imem_addr  out  ADDR_W  read address, equals the PC register
imem_rvalid  in  1  read data valid, arrives at least 1 cycle after imem_req
imem_rdata  in  INSTR_W  read data, qualified by imem_rvalid
instr_valid  out  1  instruction held for decode
instr_out  out  INSTR_W  held instruction
instr_pc  out  ADDR_W  address the held instruction was fetched from
instr_ready  in  1  decode accepts instruction
br_valid  in  1  redirect request, single-cycle pulse
br_target  in  ADDR_W  redirect address
halt  in  1  level; stop fetching while high
busy  out  1  high in REQ, WAIT and HOLD

Behaviour:
- Reset (async, active-high) sets: state IDLE, pc=RESET_PC, squash=0, imem_req=0, instr_valid=0, instr_out=0, instr_pc=0, busy=0. All outputs follow within the same cycle reset is asserted.
- imem_req and instr_valid are decoded from the registered state only. imem_addr is the pc register.
- States:
  - IDLE: if halt, go HALTED; otherwise go REQ.
  - REQ: imem_req=1 for exactly this cycle; go WAIT.
  - WAIT:
    - On imem_rvalid with squash=0: latch instr_out=imem_rdata and instr_pc=pc; pc<=pc+1; go HOLD.
    - On imem_rvalid with squash=1: discard the data, clear squash, go REQ.
  - HOLD: instr_valid=1. On instr_ready, go HALTED if halt, otherwise go REQ.
  - HALTED: no requests. When halt=0, go REQ.
- PC arithmetic is modulo 2^ADDR_W: 0xFF+1 wraps to 0x00. There are no other PC writes.
- Branch (br_valid=1): pc<=br_target in every state, with this priority over other PC updates:
  - REQ or WAIT: the in-flight read is squashed (squash<=1). Its response is dropped and the next read uses br_target. If rvalid arrives in the same cycle as br_valid in WAIT, the data is dropped, pc=br_target, and the next state is REQ.
  - HOLD: the held instruction is killed. instr_valid falls next cycle regardless of instr_ready, and the next state is REQ (HALTED if halt).
  - IDLE or HALTED: only pc updates; no state change.
- imem_rvalid outside WAIT is ignored.
- A reset during WAIT abandons the read. A late rvalid then lands in IDLE or REQ and is ignored.
- Throughput with a zero-wait-state memory and ready always high: one instruction per 3 cycles.
- instr_out and instr_pc stay stable while instr_valid=1 and instr_ready=0.

Decomposition:
- Shared package bitty_pkg holds:
  - the ADDR_W and INSTR_W constants
  - the fetch state encoding typedef: IDLE=0, REQ=1, WAIT=2, HOLD=3, HALTED=4 (3 bits)
- One natural sub-module, fetch_pc_reg: async-reset PC register with load (br_target) / increment / hold controls. Load has priority over increment.

Test Plan:
1. Release reset; imem returns {16'hA000+addr} one cycle after each req; ready=1. Expect:
   - req at cycles 1, 4, 7
   - instr_valid at cycles 3, 6 with instr_out 0xA000, 0xA001 and instr_pc 0, 1
2. Hold instr_ready=0 for 5 cycles in HOLD. Expect:
   - instr_valid held high with instr_out stable
   - no imem_req
   - pc already advanced by 1
3. br_valid with target 0x40 while in WAIT; rvalid arrives 2 cycles later with 0xDEAD. Expect:
   - 0xDEAD never presented
   - next imem_req has addr 0x40
   - first valid instruction has instr_pc 0x40
4. br_valid with target 0x10 in HOLD while ready=0. Expect:
   - instr_valid low the next cycle
   - next fetch at 0x10
5. Start pc at 0xFF (branch target 0xFF). Expect:
   - instruction delivered with instr_pc 0xFF
   - next imem_addr 0x00
6. Assert halt, then reset mid-WAIT:
   - halt=1 at HOLD handshake → HALTED, busy=0, no req; halt=0 → req resumes at pc
   - reset during WAIT → all outputs at reset values immediately, and a stale rvalid is ignored
